apb_master_bridge: RTL and testbench

- Converts a PULP-style request/grant/response-valid bus into a single APB3 master transaction stream.
- Sits directly upstream of the APB node and drives its slave port: paddr, pwdata, pwrite, psel, penable; samples prdata, pready, pslverr.
- One outstanding transaction at a time.
- A programmable timeout aborts stalled accesses with an error response.

---
 rtl/apb_bridge_pkg.sv | 15 +
 rtl/apb_bridge_timeout.sv | 33 +++
 rtl/apb_master_bridge.sv | 105 ++++++++++
 tb/tb_apb_master_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the request/grant to APB3 master bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_bridge_state_e;

  // Counter width able to hold TIMEOUT_CYCLES; never narrower than one bit.
  function automatic int unsigned timeout_cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_bridge_timeout.sv
// Saturating ACCESS-phase wait counter with clear, enable and terminal-count flag.
module apb_bridge_timeout
  import apb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  localparam int unsigned CW   = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TERM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CMAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Terminal when the count of stalled cycles already seen reaches TIMEOUT_CYCLES-1.
  assign term_c = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TERM));

endmodule

// File: rtl/apb_master_bridge.sv
// Request/grant/rvalid bus to APB3 master bridge, one outstanding access, with timeout abort.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  apb_bridge_state_e state;
  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_term;
  logic              abort;

  // Grant is only offered from IDLE and never while reset is held.
  assign gnt_o   = (state == IDLE) && req_i && !rst_i;
  assign tmo_clr = gnt_o;
  assign tmo_en  = (state == ACCESS) && !pready_i;
  assign abort   = (state == ACCESS) && !pready_i && tmo_term;

  apb_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .term_c(tmo_term)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            paddr_o  <= addr_i;
            pwdata_o <= wdata_i;
            pwrite_o <= we_i;
            psel_o   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // A ready slave takes priority over a simultaneous timeout.
          if (pready_i) begin
            rdata_o   <= pwrite_o ? '0 : prdata_i;
            err_o     <= pslverr_i;
            rvalid_o  <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= IDLE;
          end else if (abort) begin
            rdata_o   <= '0;
            err_o     <= 1'b1;
            rvalid_o  <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic vs a transaction model.
module tb_apb_master_bridge;

  localparam int TC = 4;
  localparam logic [31:0] RKEY = 32'hA5C3_0F69;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        gnt, rvalid, err, pwrite, psel, penable;
  logic [31:0] rdata, paddr, pwdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .paddr_o  (paddr),
    .pwdata_o (pwdata),
    .pwrite_o (pwrite),
    .psel_o   (psel),
    .penable_o(penable),
    .prdata_i (prdata),
    .pready_i (pready),
    .pslverr_i(pslverr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response cycle relative to grant: SETUP, then ACCESS cycles until ready or TC cycles elapsed.
  function automatic int model_lat(input int waits);
    return 3 + ((waits < TC) ? waits : TC - 1);
  endfunction

  function automatic logic [32:0] model_rsp(input logic w, input logic [31:0] a, input int waits,
                                            input logic slv);
    if (waits >= TC) return {1'b1, 32'h0};
    return {slv, (w ? 32'h0 : (a ^ RKEY))};
  endfunction

  // Runs one transfer starting in an IDLE cycle; returns in the response cycle, without advancing.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                         input logic slv, input logic [31:0] prd, input logic exp_err,
                         input logic [31:0] exp_rdata, input int exp_lat, input logic busy_req);
    bit done = 0;
    req = 1'b1; we = w; addr = a; wdata = d; pready = 1'b0;
    #1;
    chk("gnt_idle", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    for (int k = 1; k <= 24 && !done; k++) begin
      if (rvalid) begin
        chk("rsp_lat", 32'(k), 32'(exp_lat));
        chk("rsp_err", 32'(err), 32'(exp_err));
        chk("rsp_rdata", rdata, exp_rdata);
        chk("psel_drop", 32'({psel, penable}), 32'd0);
        done = 1;
      end else begin
        chk("psel", 32'(psel), 32'd1);
        chk("penable", 32'(penable), 32'(k >= 2));
        chk("paddr", paddr, a);
        chk("pwrite", 32'(pwrite), 32'(w));
        chk("pwdata", pwdata, d);
        req = busy_req; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        pready = penable && ((k - 2) == waits);
        pslverr = pready ? slv : 1'($urandom);
        prdata = pready ? prd : $urandom;
        #1;
        chk("gnt_busy", 32'(gnt), 32'd0);
        @(posedge clk); #1;
      end
    end
    pready = 1'b0;
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle(input logic [31:0] hold_rdata, input logic hold_err);
    req = 1'b0; pready = 1'b0;
    tick();
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("hold_rdata", rdata, hold_rdata);
    chk("hold_err", 32'(err), 32'(hold_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [32:0] rsp;
    logic        rw, rs;
    logic [31:0] ra, rd;
    int          rwait;

    vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         0,   1'b0, 1'b0, 32'h0,         3};
    vecs[1] = '{1'b0, 32'h2000_0000, 32'h0,         32'h1234_5678, 3,   1'b0, 1'b0, 32'h1234_5678, 6};
    vecs[2] = '{1'b0, 32'h3000_0010, 32'h0,         32'hCAFE_F00D, 1,   1'b1, 1'b1, 32'hCAFE_F00D, 4};
    vecs[3] = '{1'b0, 32'h4000_0000, 32'h0,         32'h5555_AAAA, 100, 1'b0, 1'b1, 32'h0,         6};
    vecs[4] = '{1'b0, 32'h4000_0004, 32'h0,         32'h0BAD_CAFE, 0,   1'b0, 1'b0, 32'h0BAD_CAFE, 3};
    vecs[5] = '{1'b1, 32'h5000_0000, 32'h7777_1111, 32'hFFFF_FFFF, 2,   1'b1, 1'b1, 32'h0,         5};

    // Reset state.
    tick(); tick();
    chk("rst_psel", 32'({psel, penable, rvalid, err, pwrite, gnt}), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'({psel, rvalid}), 32'd0);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].slverr,
              vecs[i].prdata, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat, 1'b0);
      idle_cycle(vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back writes with req held: next grant lands in the response cycle.
    run_txn(1'b1, 32'h6000_0000, 32'h0000_0001, 0, 1'b0, 32'h0, 1'b0, 32'h0, 3, 1'b1);
    chk("b2b_rvalid", 32'(rvalid), 32'd1);
    run_txn(1'b1, 32'h6000_0004, 32'h0000_0002, 1, 1'b0, 32'h0, 1'b0, 32'h0, 4, 1'b1);
    idle_cycle(32'h0, 1'b0);

    // Reset during ACCESS drops the transfer with no response.
    req = 1'b1; we = 1'b0; addr = 32'h7000_0000; wdata = 32'h0;
    tick();
    req = 1'b0;
    tick();
    chk("pre_rst_access", 32'({psel, penable}), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_drop", 32'({psel, penable, rvalid}), 32'd0);
    tick();
    chk("rst_no_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_no_rvalid", 32'({rvalid, psel}), 32'd0);
    run_txn(1'b0, 32'h7000_0008, 32'h0, 0, 1'b0, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF ^ 32'h0, 3, 1'b0);

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 40; n++) begin
      int gap;
      rw = 1'($urandom); ra = $urandom; rd = $urandom;
      rwait = $urandom_range(0, 6); rs = 1'($urandom);
      rsp = model_rsp(rw, ra, rwait, rs);
      run_txn(rw, ra, rd, rwait, rs, ra ^ RKEY, rsp[32], rsp[31:0], model_lat(rwait),
              1'($urandom));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(rsp[31:0], rsp[32]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
